// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 binary max-pool sequencer.
package pool_pkg;

  localparam int unsigned MAP_W_DEF   = 8;
  localparam int unsigned MAP_H_DEF   = 8;
  localparam int unsigned N_MAPS_DEF  = 32;
  localparam int unsigned WIN_PER_MAP = (MAP_W_DEF / 2) * (MAP_H_DEF / 2);
  localparam int unsigned TOTAL_WIN   = N_MAPS_DEF * WIN_PER_MAP;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    EMIT  = 3'd3,
    FIN   = 3'd4
  } state_e;

  // Counter width that stays at least one bit for degenerate (size 1) ranges.
  function automatic int unsigned cnt_w(input int unsigned n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window walker: map/row/col counters, linear output index and RAM address of
// the (dy,dx) sample selected by sel_i = {dy, dx}.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int unsigned MAP_W  = MAP_W_DEF,
  parameter int unsigned MAP_H  = MAP_H_DEF,
  parameter int unsigned N_MAPS = N_MAPS_DEF,
  parameter int unsigned AW     = 11,
  parameter int unsigned OW     = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  input  logic [1:0]    sel_i,
  output logic [AW-1:0] addr_o,
  output logic [OW-1:0] idx_o,
  output logic          last_o
);

  localparam int unsigned CW = cnt_w(MAP_W / 2);
  localparam int unsigned RW = cnt_w(MAP_H / 2);
  localparam int unsigned MW = cnt_w(N_MAPS);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [MW-1:0] map_q, map_d;
  logic [OW-1:0] idx_q, idx_d;
  logic          col_max_s, row_max_s, map_max_s;

  always_comb begin
    col_max_s = (col_q == CW'(MAP_W / 2 - 1));
    row_max_s = (row_q == RW'(MAP_H / 2 - 1));
    map_max_s = (map_q == MW'(N_MAPS - 1));
    last_o    = col_max_s && row_max_s && map_max_s;
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    map_d = map_q;
    idx_d = idx_q;
    if (clr_i || (adv_i && last_o)) begin
      col_d = {CW{1'b0}};
      row_d = {RW{1'b0}};
      map_d = {MW{1'b0}};
      idx_d = {OW{1'b0}};
    end else if (adv_i) begin
      idx_d = idx_q + OW'(1);
      if (col_max_s) begin
        col_d = {CW{1'b0}};
        if (row_max_s) begin
          row_d = {RW{1'b0}};
          map_d = map_q + MW'(1);
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= {CW{1'b0}};
      row_q <= {RW{1'b0}};
      map_q <= {MW{1'b0}};
      idx_q <= {OW{1'b0}};
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      map_q <= map_d;
      idx_q <= idx_d;
    end
  end

  // {row,dy} and {col,dx} are 2r+dy and 2c+dx without a multiplier.
  always_comb begin
    addr_o = AW'(map_q) * AW'(MAP_W * MAP_H)
           + AW'({row_q, sel_i[1]}) * AW'(MAP_W)
           + AW'({col_q, sel_i[0]});
    idx_o  = idx_q;
  end

endmodule

// File: rtl/pool_sched.sv
// 2x2 binary max-pool sequencer: reads each window, ORs it, streams one bit out.
// Optional POOL_SCHED_ONES_CNT_EN adds a ones_cnt output of accepted 1-windows.
module pool_sched
  import pool_pkg::*;
#(
  parameter int unsigned MAP_W  = MAP_W_DEF,
  parameter int unsigned MAP_H  = MAP_H_DEF,
  parameter int unsigned N_MAPS = N_MAPS_DEF,
  parameter int unsigned AW     = 11,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned OW     = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic [OW-1:0] out_idx
`ifdef POOL_SCHED_ONES_CNT_EN
  ,
  output logic [OW:0]   ones_cnt
`endif
);

  state_e state_q, state_d;
  logic [1:0]        iss_q, iss_d;
  logic [1:0]        cap_q, cap_d;
  logic [3:0]        smp_q, smp_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic              cap_s, hs_s, enter_s, last_s;
  logic [AW-1:0]     addr_s;
  logic [OW-1:0]     idx_s;

  pool_addr_gen #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H),
    .N_MAPS(N_MAPS),
    .AW    (AW),
    .OW    (OW)
  ) u_addr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == FIN),
    .adv_i (hs_s),
    .sel_i (iss_q),
    .addr_o(addr_s),
    .idx_o (idx_s),
    .last_o(last_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving DRAIN is keyed to the fourth returned sample, not a cycle count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE; else state_d = IDLE;
      ISSUE:   if (iss_q == 2'd3) state_d = DRAIN; else state_d = ISSUE;
      DRAIN:   if (cap_s && (cap_q == 2'd3)) state_d = EMIT; else state_d = DRAIN;
      EMIT: begin
        if (out_ready) begin
          if (last_s) state_d = FIN; else state_d = ISSUE;
        end else begin
          state_d = EMIT;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = {AW{1'b0}};
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_idx   = idx_s;
    case (state_q)
      IDLE:  busy = 1'b0;
      ISSUE: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = addr_s;
      end
      DRAIN: busy = 1'b1;
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_bit   = |smp_q;
      end
      FIN:     done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_comb begin
    hs_s    = (state_q == EMIT) && out_ready;
    cap_s   = vld_q[RD_LAT-1];
    enter_s = (state_q != ISSUE) && (state_d == ISSUE);
    vld_d    = vld_q;
    vld_d[0] = (state_q == ISSUE);
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    if (state_q == ISSUE) begin
      iss_d = iss_q + 2'd1;
    end else begin
      iss_d = 2'd0;
    end
    cap_d = cap_q;
    smp_d = smp_q;
    if (enter_s) begin
      cap_d = 2'd0;
      smp_d = 4'd0;
    end else if (cap_s) begin
      cap_d        = cap_q + 2'd1;
      smp_d[cap_q] = rd_data;
    end else begin
      cap_d = cap_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_q <= 2'd0;
      cap_q <= 2'd0;
      smp_q <= 4'd0;
      vld_q <= {RD_LAT{1'b0}};
    end else begin
      iss_q <= iss_d;
      cap_q <= cap_d;
      smp_q <= smp_d;
      vld_q <= vld_d;
    end
  end

`ifdef POOL_SCHED_ONES_CNT_EN
  logic [OW:0] ones_q, ones_d;

  always_comb begin
    if ((state_q == IDLE) && start) begin
      ones_d = {(OW+1){1'b0}};
    end else if (hs_s && (|smp_q)) begin
      ones_d = ones_q + (OW+1)'(1);
    end else begin
      ones_d = ones_q;
    end
    ones_cnt = ones_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= {(OW+1){1'b0}};
    end else begin
      ones_q <= ones_d;
    end
  end
`endif

endmodule

// File: tb/tb_pool_sched.sv
// Scoreboard bench for pool_sched with a latency-RD_LAT RAM model.
module tb_pool_sched;

  localparam int MAP_W  = 8;
  localparam int MAP_H  = 8;
  localparam int N_MAPS = 32;
  localparam int AW     = 11;
  localparam int RD_LAT = 2;
  localparam int OW     = 9;
  localparam int NWORDS = N_MAPS * MAP_W * MAP_H;

  logic          clk = 1'b0;
  logic          rst, start, out_ready, rd_data;
  logic          busy, done, rd_en, out_valid, out_bit;
  logic [AW-1:0] rd_addr;
  logic [OW-1:0] out_idx;
`ifdef POOL_SCHED_ONES_CNT_EN
  logic [OW:0]   ones_cnt;
`endif

  typedef struct {
    int idx;
    int b;
  } exp_t;

  bit   mem [NWORDS];
  logic p1_q = 1'b0;
  logic p2_q = 1'b0;
  exp_t exp_q[$];
  int   addr_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   exp_ones = 0;
  bit   ab;

  pool_sched #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .N_MAPS(N_MAPS),
    .AW(AW), .RD_LAT(RD_LAT), .OW(OW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_idx(out_idx)
`ifdef POOL_SCHED_ONES_CNT_EN
    , .ones_cnt(ones_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RAM port B with two cycles of read latency
  always @(posedge clk) begin
    p1_q <= rd_en ? mem[rd_addr] : 1'b0;
    p2_q <= p1_q;
  end
  assign rd_data = p2_q;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: every window of every map, reads in (dy,dx) order, bit = OR of 4.
  task automatic build_exp();
    int a, b, idx;
    exp_q.delete();
    addr_q.delete();
    exp_ones = 0;
    idx = 0;
    for (int m = 0; m < N_MAPS; m++)
      for (int r = 0; r < MAP_H / 2; r++)
        for (int c = 0; c < MAP_W / 2; c++) begin
          b = 0;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              a = m * MAP_W * MAP_H + (2 * r + dy) * MAP_W + 2 * c + dx;
              addr_q.push_back(a);
              if (mem[a]) b = 1;
            end
          exp_q.push_back('{idx: idx, b: b});
          exp_ones += b;
          idx++;
        end
  endtask

  // Monitor: pops expected reads and outputs whenever the DUT presents them.
  always @(negedge clk) begin : mon
    int   a;
    exp_t e;
    if (!rst) begin
      if (rd_en) begin
        if (addr_q.size() == 0) chk("rd_spurious", 1, 0);
        else begin
          a = addr_q.pop_front();
          chk("rd_addr", int'(rd_addr), a);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("out_spurious", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_idx", int'(out_idx), e.idx);
          chk("out_bit", int'(out_bit), e.b);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_rd_en"}, rd_en, 0);
    chk({pfx, "_rd_addr"}, int'(rd_addr), 0);
    chk({pfx, "_valid"}, out_valid, 0);
    chk({pfx, "_bit"}, out_bit, 0);
    chk({pfx, "_idx"}, int'(out_idx), 0);
  endtask

  task automatic do_start(input bit lat);
    build_exp();
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (lat) begin
      for (int j = 1; j <= 7; j++) begin
        @(negedge clk);
        chk("lat_rd_en", rd_en, int'(j <= 4));
        chk("lat_valid", out_valid, int'(j == 7));
        if (j == 1) begin
          chk("busy_on", busy, 1);
`ifdef POOL_SCHED_ONES_CNT_EN
          chk("ones_clr", int'(ones_cnt), 0);
`endif
        end
      end
    end
  endtask

  // mode 0: ready=1; 1: random ready + start held; 2: stall at bp_idx; 3: abort at ab_idx
  task automatic run(input int mode, input int bp_idx, input int ab_idx, output bit aborted);
    bit stalled, fin;
    stalled = 1'b0;
    fin     = 1'b0;
    aborted = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) begin
        fin = 1'b1;
        break;
      end
      if (mode == 1) begin
        out_ready = ($urandom_range(0, 3) != 0);
        start     = 1'b1;
      end else begin
        out_ready = 1'b1;
      end
      if (mode == 2 && !stalled && out_valid && int'(out_idx) == bp_idx) begin
        stalled   = 1'b1;
        out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          chk("hold_valid", out_valid, 1);
          chk("hold_idx", int'(out_idx), bp_idx);
          chk("hold_bit", out_bit, (exp_q.size() > 0) ? exp_q[0].b : -1);
          chk("hold_rd_en", rd_en, 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      if (mode == 3 && rd_en && int'(out_idx) == ab_idx && rd_addr[0]) begin
        rst = 1'b1;
        #1 chk_zero("abort_now");
        @(negedge clk);
        chk_zero("abort_next");
        chk("abort_no_done", done_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        aborted = 1'b1;
        fin     = 1'b1;
        break;
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    if (!fin) chk("timeout", 1, 0);
    if (fin && !aborted) begin
      repeat (3) @(negedge clk);
      chk("done_once", done_cnt, 1);
      chk("busy_after", busy, 0);
      chk("exp_left", exp_q.size(), 0);
      chk("addr_left", addr_q.size(), 0);
`ifdef POOL_SCHED_ONES_CNT_EN
      chk("ones_cnt", int'(ones_cnt), exp_ones);
`endif
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NWORDS; i++) mem[i] = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < NWORDS; i++) mem[i] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    do_start(1'b1); run(0, -1, -1, ab);                 // all-zero RAM
    mem[9] = 1'b1;
    do_start(1'b0); run(0, -1, -1, ab);                 // only first window set
    mem[9] = 1'b0; mem[64 * 31 + 63] = 1'b1;
    do_start(1'b0); run(0, -1, -1, ab);                 // only last window set
    fill_rand();
    do_start(1'b1); run(1, -1, -1, ab);                 // random ready, start held
    fill_rand();
    do_start(1'b0); run(2, 5, -1, ab);                  // backpressure at idx 5
    fill_rand();
    do_start(1'b0); run(3, -1, 100, ab);                // reset mid-ISSUE
    chk("abort_taken", ab, 1);
    do_start(1'b1); run(0, -1, -1, ab);                 // restart from idx 0
    for (int i = 0; i < NWORDS; i++) mem[i] = (((i / (MAP_W * MAP_H)) % 2) == 0);
    do_start(1'b0); run(0, -1, -1, ab);                 // even maps all ones
    repeat (5) @(negedge clk);
`ifdef POOL_SCHED_ONES_CNT_EN
    chk("ones_hold", int'(ones_cnt), exp_ones);
`endif
    do_start(1'b1); run(0, -1, -1, ab);                 // second start clears count

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
